// File: rtl/fmap_bram_writer.sv
// Feature-map write-back engine: requantizes signed results to 8 bits and writes them row-major to BRAM port A.
// Optional macro FMAP_WRITER_RELU_EN selects ReLU clamping (0..255); the default build clamps signed to -128..127.
module fmap_bram_writer #(
    parameter int IN_W   = 16,
    parameter int ADDR_W = 11,
    parameter int DIM_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [DIM_W-1:0]       i_hs_num,
    input  logic [DIM_W-1:0]       i_vs_num,
    input  logic [DIM_W-1:0]       i_pitch,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [3:0]             i_shift,
    input  logic                   i_data_en,
    input  logic signed [IN_W-1:0] i_data_in,
    output logic                   o_ready,
    output logic                   o_ena,
    output logic                   o_wea,
    output logic [ADDR_W-1:0]      o_addra,
    output logic [7:0]             o_dina,
    output logic                   o_busy,
    output logic                   o_frame_done
);

    // state   | meaning
    // S_IDLE  | waiting for i_start, configuration not yet latched
    // S_WRITE | accepting one beat per cycle, writing row-major
    // S_DONE  | last strobe (if any) visible, frame_done pulse
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   hs_q, hs_d, vs_q, vs_d, pitch_q, pitch_d;
    logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
    logic [3:0]         shift_q, shift_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               ena_q, ena_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         dina_q, dina_d;
    logic signed [IN_W-1:0] shifted;
    logic [7:0]         quant;

    localparam logic signed [IN_W-1:0] S_MAX = IN_W'(127);
    localparam logic signed [IN_W-1:0] S_MIN = -IN_W'(128);
    localparam logic signed [IN_W-1:0] U_MAX = IN_W'(255);

    always_comb begin
        shifted = i_data_in >>> shift_q;
`ifdef FMAP_WRITER_RELU_EN
        if (shifted[IN_W-1])       quant = 8'h00;
        else if (shifted > U_MAX)  quant = 8'hFF;
        else                       quant = shifted[7:0];
`else
        if (shifted > S_MAX)       quant = 8'h7F;
        else if (shifted < S_MIN)  quant = 8'h80;
        else                       quant = shifted[7:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        pitch_d    = pitch_q;
        shift_d    = shift_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        ena_d      = 1'b0;
        addr_d     = addr_q;
        dina_d     = dina_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    hs_d       = i_hs_num;
                    vs_d       = i_vs_num;
                    pitch_d    = i_pitch;
                    shift_d    = i_shift;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = i_base_addr;
                    state_d    = (i_hs_num == '0 || i_vs_num == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_data_en) begin
                    ena_d  = 1'b1;
                    addr_d = row_base_q + ADDR_W'(col_q);
                    dina_d = quant;
                    if (col_q == hs_q - DIM_W'(1)) begin
                        col_d      = '0;
                        row_d      = row_q + DIM_W'(1);
                        row_base_d = row_base_q + ADDR_W'(pitch_q);
                        if (row_q == vs_q - DIM_W'(1)) state_d = S_DONE;
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            hs_q       <= '0;
            vs_q       <= '0;
            pitch_q    <= '0;
            shift_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            ena_q      <= 1'b0;
            addr_q     <= '0;
            dina_q     <= '0;
        end else begin
            state_q    <= state_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            pitch_q    <= pitch_d;
            shift_q    <= shift_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            ena_q      <= ena_d;
            addr_q     <= addr_d;
            dina_q     <= dina_d;
        end
    end

    assign o_ready      = (state_q == S_WRITE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = (state_q == S_DONE);
    assign o_ena        = ena_q;
    assign o_wea        = ena_q;
    assign o_addra      = addr_q;
    assign o_dina       = dina_q;

endmodule

// File: tb/tb_fmap_bram_writer.sv
// Directed bench for fmap_bram_writer; expectations follow FMAP_WRITER_RELU_EN when defined.
module tb_fmap_bram_writer;
    localparam int IN_W = 16, ADDR_W = 11, DIM_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic i_start, i_data_en;
    logic [DIM_W-1:0] i_hs_num, i_vs_num, i_pitch;
    logic [ADDR_W-1:0] i_base_addr;
    logic [3:0] i_shift;
    logic signed [IN_W-1:0] i_data_in;
    logic o_ready, o_ena, o_wea, o_busy, o_frame_done;
    logic [ADDR_W-1:0] o_addra;
    logic [7:0] o_dina;

    fmap_bram_writer #(.IN_W(IN_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_hs_num(i_hs_num),
        .i_vs_num(i_vs_num), .i_pitch(i_pitch), .i_base_addr(i_base_addr),
        .i_shift(i_shift), .i_data_en(i_data_en), .i_data_in(i_data_in),
        .o_ready(o_ready), .o_ena(o_ena), .o_wea(o_wea), .o_addra(o_addra),
        .o_dina(o_dina), .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    logic [ADDR_W-1:0] rec_addr[$];
    logic [7:0]        rec_dina[$];
    bit                rec_done[$];
    int  n_done = 0, align_err = 0, busy_err = 0;
    bit  align_on = 1'b0, done_prev = 1'b0;
    logic acc_q = 1'b0;
    int  din[$];

    always @(posedge clk) acc_q <= i_data_en && o_ready;

    always @(negedge clk) begin
        if (o_ena === 1'b1) begin
            rec_addr.push_back(o_addra);
            rec_dina.push_back(o_dina);
            rec_done.push_back(o_frame_done);
            if (o_wea !== 1'b1) align_err++;
        end
        if (o_frame_done === 1'b1) begin
            n_done++;
            if (o_busy !== 1'b1) busy_err++;
        end
        if (done_prev && o_busy !== 1'b0) busy_err++;
        done_prev = (o_frame_done === 1'b1);
        if (align_on && (o_ena !== acc_q)) align_err++;
    end

    task automatic clear_rec();
        rec_addr.delete(); rec_dina.delete(); rec_done.delete(); n_done = 0;
    endtask

    task automatic run_frame(input int hs, input int vs, input int pitch, input int base,
                             input int sh, input bit gapped, input int mid_start,
                             input int abort_after);
        int idx = 0;
        int cyc = 0;
        clear_rec();
        i_hs_num = DIM_W'(hs); i_vs_num = DIM_W'(vs); i_pitch = DIM_W'(pitch);
        i_base_addr = ADDR_W'(base); i_shift = 4'(sh);
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        while (idx < din.size() && cyc < 500) begin
            if (abort_after >= 0 && idx == abort_after) return;
            i_start = (mid_start >= 0 && idx == mid_start);
            if (o_ready && (!gapped || (cyc % 2) == 0)) begin
                i_data_en = 1'b1;
                i_data_in = IN_W'(din[idx]);
                idx++;
            end else begin
                i_data_en = 1'b0;
            end
            @(negedge clk); cyc++;
        end
        i_data_en = 1'b0; i_start = 1'b0;
        check("beats_driven", idx, din.size());
        #1;
        cyc = 0;
        while (n_done == 0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        repeat (3) @(negedge clk);
        #1;
        check("frame_done_cnt", n_done, 1);
        check("busy_idle", o_busy, 0);
    endtask

    task automatic check_frame(input string tag, input int ea[$], input int ed[$]);
        check({tag, "_nstrobe"}, rec_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < rec_addr.size(); i++) begin
            check({tag, "_addr"}, rec_addr[i], ea[i]);
            check({tag, "_dina"}, rec_dina[i], ed[i]);
            check({tag, "_done_pos"}, rec_done[i], (i == ea.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ea[$];
        int ed[$];
        rst = 1'b1; i_start = 1'b0; i_data_en = 1'b0; i_data_in = '0;
        i_hs_num = '0; i_vs_num = '0; i_pitch = '0; i_base_addr = '0; i_shift = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", o_ready, 0);
        check("rst_ena", o_ena, 0);
        check("rst_wea", o_wea, 0);
        check("rst_addra", o_addra, 0);
        check("rst_dina", o_dina, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_frame_done, 0);
        rst = 1'b0;
        @(negedge clk); align_on = 1'b1;

        // 7x7 back-to-back
        din.delete(); ea.delete(); ed.delete();
        for (int i = 0; i < 49; i++) begin din.push_back(i); ea.push_back(i); ed.push_back(i); end
        run_frame(7, 7, 7, 0, 0, 1'b0, -1, -1);
        check_frame("f7x7", ea, ed);

        // 3x2 gapped, base 100 pitch 8
        din = '{1, 2, 3, 4, 5, 6};
        ea = '{100, 101, 102, 108, 109, 110};
        ed = '{1, 2, 3, 4, 5, 6};
        run_frame(3, 2, 8, 100, 0, 1'b1, -1, -1);
        check_frame("gap", ea, ed);

        // requantization, shift 2
        din = '{1000, -20, 300};
        ea = '{0, 1, 2};
`ifdef FMAP_WRITER_RELU_EN
        ed = '{8'hFA, 8'h00, 8'h4B};
`else
        ed = '{8'h7F, 8'hFB, 8'h4B};
`endif
        run_frame(3, 1, 3, 0, 2, 1'b0, -1, -1);
        check_frame("quant", ea, ed);

        // address wrap plus ignored mid-frame start
        din = '{10, 11, 12, 13};
        ea = '{2046, 2047, 0, 1};
        ed = '{10, 11, 12, 13};
        run_frame(4, 1, 4, 2046, 0, 1'b0, 1, -1);
        check_frame("wrap", ea, ed);

        // zero-size frame
        clear_rec();
        i_hs_num = '0; i_vs_num = 8'd3;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0; #1;
        check("zero_done", o_frame_done, 1);
        check("zero_ready", o_ready, 0);
        repeat (3) @(negedge clk); #1;
        check("zero_nstrobe", rec_addr.size(), 0);
        check("zero_done_cnt", n_done, 1);
        check("zero_busy", o_busy, 0);

        // reset after 10 of 49 beats
        din.delete();
        for (int i = 0; i < 49; i++) din.push_back(i);
        run_frame(7, 7, 7, 0, 0, 1'b0, -1, 10);
        align_on = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ready", o_ready, 0);
        check("arst_ena", o_ena, 0);
        check("arst_wea", o_wea, 0);
        check("arst_addra", o_addra, 0);
        check("arst_dina", o_dina, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_frame_done, 0);
        i_data_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); align_on = 1'b1;
        ea.delete(); ed.delete();
        for (int i = 0; i < 49; i++) begin ea.push_back(i); ed.push_back(i); end
        run_frame(7, 7, 7, 0, 0, 1'b0, -1, -1);
        check_frame("restart", ea, ed);

        check("strobe_align_err", align_err, 0);
        check("busy_err", busy_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
